// File: rtl/half_adder2.sv
`timescale 1ns/1ns
// -----------------------------------------------------------------------------
// half_adder2
//   Single-bit half adder with two views of the same result:
//     * a zero-cycle gate-level path (sum/carry), each output one gate primitive
//       with GATE_DELAY of modelled delay, so a full adder built from two of
//       these plus an OR gate stays purely combinational;
//     * a registered copy (sum_q/carry_q/out_valid) with saturating activity
//       counters for pipelined users and bring-up visibility.
//
//   Optional self-check: define HALFADDER2_CHECK_EN to build a checker that
//   compares the gate outputs against a+b on accepted cycles and raises a
//   sticky err. Without the macro err is tied low and no checker is built.
//
// Parameters
//   GATE_DELAY  simulation delay per gate primitive (ignored by synthesis)
//   CNT_W       width of op_count / carry_count
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (overrides every other input)
//   a, b         addend bits
//   sum, carry   combinational a^b / a&b through one delayed gate each
//   in_valid     qualifies a/b for the registered stage and the counters
//   cnt_clr      synchronous clear of both counters (wins over increment)
//   sum_q        registered sum
//   carry_q      registered carry
//   out_valid    in_valid delayed by one cycle
//   op_count     saturating count of accepted operations
//   carry_count  saturating count of accepted operations with carry=1
//   err          sticky self-check error (0 unless HALFADDER2_CHECK_EN)
//
// Valid semantics: a cycle is accepted whenever in_valid=1 at the rising edge
// with rst=0. There is no ready/back-pressure; every valid cycle is taken and
// appears on sum_q/carry_q with out_valid=1 exactly one cycle later.
// -----------------------------------------------------------------------------
module half_adder2 #(
  parameter int GATE_DELAY = 50,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             carry,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             sum_q,
  output logic             carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Gate-level combinational path with modelled delay.
  xor #(GATE_DELAY) u_sum_gate   (sum, a, b);
  and #(GATE_DELAY) u_carry_gate (carry, a, b);

  // Zero-delay copy feeding the registers, so what gets captured never depends
  // on how GATE_DELAY relates to the clock period.
  logic sum_i;
  logic carry_i;
  assign sum_i   = a ^ b;
  assign carry_i = a & b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid   <= 1'b0;
      op_count    <= '0;
      carry_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_i;
        carry_q <= carry_i;
      end
      // Clear wins over increment: the operation in a clear cycle is dropped.
      if (cnt_clr) begin
        op_count    <= '0;
        carry_count <= '0;
      end else if (in_valid) begin
        if (op_count != CNT_MAX) begin
          op_count <= op_count + 1'b1;
        end
        // carry_count only moves on cycles op_count also counts and both
        // saturate at the same ceiling, so carry_count <= op_count holds.
        if (carry_i && (carry_count != CNT_MAX)) begin
          carry_count <= carry_count + 1'b1;
        end
      end
    end
  end

`ifdef HALFADDER2_CHECK_EN
`ifndef SYNTHESIS
  // Time of the most recent change on either input. The gate outputs are only
  // trustworthy once the inputs have been quiet for a full GATE_DELAY.
  realtime last_chg = 0.0;
  always @(a or b) last_chg = $realtime;

  function automatic logic inputs_settled();
    return ($realtime - last_chg) >= GATE_DELAY;
  endfunction
`else
  function automatic logic inputs_settled();
    return 1'b1;
  endfunction
`endif

  logic [1:0] ref_sum;
  assign ref_sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_valid && inputs_settled() && ({carry, sum} != ref_sum)) begin
      err <= 1'b1;
`ifndef SYNTHESIS
      $display("half_adder2 error: a=%b b=%b gate out {carry,sum}=%b expected %b",
               a, b, {carry, sum}, ref_sum);
`endif
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_half_adder2.sv
`timescale 1ns/1ns
// Bench for half_adder2: a main instance (CNT_W=16), a narrow instance
// (CNT_W=2) sharing the same inputs to reach counter saturation, and a full
// adder built from two instances plus an OR gate.
module tb_half_adder2;

  localparam int GD       = 50;
  localparam int MAX_MAIN = 65535;
  localparam int MAX_SAT  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #100 clk = ~clk;

  logic rst, a, b, in_valid, cnt_clr;

  // main instance
  logic        sum, carry, sum_q, carry_q, out_valid, err;
  logic [15:0] op_count, carry_count;

  // narrow-counter instance
  logic       s_sum, s_carry, s_sum_q, s_carry_q, s_out_valid, s_err;
  logic [1:0] s_op_count, s_carry_count;

  // full adder
  logic fa_a, fa_b, fa_c, fa_v, fa_s, fa_co;
  logic h1_s, h1_c, h1_sq, h1_cq, h1_ov, h1_err;
  logic h2_c, h2_sq, h2_cq, h2_ov, h2_err;
  logic [15:0] h1_opc, h1_cc, h2_opc, h2_cc;

  half_adder2 #(.GATE_DELAY(GD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum), .carry(carry),
    .in_valid(in_valid), .cnt_clr(cnt_clr), .sum_q(sum_q), .carry_q(carry_q),
    .out_valid(out_valid), .op_count(op_count), .carry_count(carry_count), .err(err)
  );

  half_adder2 #(.GATE_DELAY(GD), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .sum(s_sum), .carry(s_carry),
    .in_valid(in_valid), .cnt_clr(cnt_clr), .sum_q(s_sum_q), .carry_q(s_carry_q),
    .out_valid(s_out_valid), .op_count(s_op_count), .carry_count(s_carry_count), .err(s_err)
  );

  half_adder2 #(.GATE_DELAY(GD), .CNT_W(16)) fa_h1 (
    .clk(clk), .rst(rst), .a(fa_a), .b(fa_b), .sum(h1_s), .carry(h1_c),
    .in_valid(fa_v), .cnt_clr(1'b0), .sum_q(h1_sq), .carry_q(h1_cq),
    .out_valid(h1_ov), .op_count(h1_opc), .carry_count(h1_cc), .err(h1_err)
  );

  half_adder2 #(.GATE_DELAY(GD), .CNT_W(16)) fa_h2 (
    .clk(clk), .rst(rst), .a(h1_s), .b(fa_c), .sum(fa_s), .carry(h2_c),
    .in_valid(fa_v), .cnt_clr(1'b0), .sum_q(h2_sq), .carry_q(h2_cq),
    .out_valid(h2_ov), .op_count(h2_opc), .carry_count(h2_cc), .err(h2_err)
  );

  or #(GD) u_fa_or (fa_co, h1_c, h2_c);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the result is the arithmetic a+b, the counters are plain
  // integers clamped at their ceiling.
  bit m_valid, m_sum, m_carry;
  int m_ops, m_car, s_ops, s_car;

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit x, input bit y, input bit clr);
    int s;
    s = int'(x) + int'(y);
    if (r) begin
      m_valid = 0; m_sum = 0; m_carry = 0;
      m_ops = 0; m_car = 0; s_ops = 0; s_car = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_sum   = (s % 2) == 1;
        m_carry = (s == 2);
      end
      if (clr) begin
        m_ops = 0; m_car = 0; s_ops = 0; s_car = 0;
      end else if (v) begin
        m_ops = sat_inc(m_ops, MAX_MAIN);
        s_ops = sat_inc(s_ops, MAX_SAT);
        if (s == 2) begin
          m_car = sat_inc(m_car, MAX_MAIN);
          s_car = sat_inc(s_car, MAX_SAT);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, sample 1 unit after the rising edge.
  task automatic cycle(input bit r, input bit v, input bit x, input bit y, input bit clr);
    logic [2:0] exp_w;
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y; cnt_clr = clr;
    model_step(r, v, x, y, clr);
    exp_q.push_back({m_valid, m_carry, m_sum});
    @(posedge clk);
    #1;
    exp_w = exp_q.pop_front();
    check("regs", int'({out_valid, carry_q, sum_q}), int'(exp_w));
    check("sat_regs", int'({s_out_valid, s_carry_q, s_sum_q}), int'(exp_w));
    check("op_count", int'(op_count), m_ops);
    check("carry_count", int'(carry_count), m_car);
    check("sat_op_count", int'(s_op_count), s_ops);
    check("sat_carry_count", int'(s_carry_count), s_car);
    check("err", int'(err), 0);
    // inputs changed a full half period ago, well beyond GATE_DELAY
    check("comb_settled", int'({carry, sum}), int'(x) + int'(y));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit x;
    bit y;
    bit s;
    bit c;
  } comb_vec_t;

  comb_vec_t ctab[4];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_s, prev_c;
    int fa_exp;

    rst = 1'b1; a = 1'b1; b = 1'b1; in_valid = 1'b1; cnt_clr = 1'b0;
    fa_a = 1'b0; fa_b = 1'b0; fa_c = 1'b0; fa_v = 1'b1;

    ctab[0] = '{x: 0, y: 0, s: 0, c: 0};
    ctab[1] = '{x: 0, y: 1, s: 1, c: 0};
    ctab[2] = '{x: 1, y: 0, s: 1, c: 0};
    ctab[3] = '{x: 1, y: 1, s: 0, c: 1};

    // Reset held 2 cycles with valid 11 on the inputs.
    cycle(1, 1, 1, 1, 0);
    cycle(1, 1, 1, 1, 0);
    check("reset_op_count", int'(op_count), 0);
    cycle(0, 0, 1, 1, 0);

    // Combinational truth table with gate delay: still old value just before
    // GATE_DELAY elapses, new value just after.
    prev_s = 1'b0; prev_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = ctab[i].x; b = ctab[i].y;
      #(GD - 1);
      check("comb_hold_sum", int'(sum), int'(prev_s));
      check("comb_hold_carry", int'(carry), int'(prev_c));
      #2;
      check("comb_sum", int'(sum), int'(ctab[i].s));
      check("comb_carry", int'(carry), int'(ctab[i].c));
      prev_s = ctab[i].s; prev_c = ctab[i].c;
      #GD;
    end

    // Registered path: capture 11, then an idle cycle holds it.
    cycle(0, 1, 1, 1, 0);
    check("regpath_capture", int'({out_valid, carry_q, sum_q}), 3'b110);
    cycle(0, 0, 1, 0, 0);
    check("regpath_hold", int'({out_valid, carry_q, sum_q}), 3'b010);

    // Counting from a clean clear.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 0, 0, 0);
    check("count4_op", int'(op_count), 4);
    check("count4_carry", int'(carry_count), 2);

    // Clear beats a simultaneous valid 11.
    cycle(0, 1, 1, 1, 1);
    check("clr_prio_op", int'(op_count), 0);
    check("clr_prio_carry", int'(carry_count), 0);

    // Saturation on the 2-bit counters.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 0);
    check("sat_op", int'(s_op_count), 3);
    check("sat_carry", int'(s_carry_count), 3);
    check("nosat_op", int'(op_count), 5);

    // Valid then reset: pending result discarded.
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 0);
    check("midreset_valid", int'(out_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(39) == 0, $urandom_range(2) != 0,
            1'($urandom_range(1)), 1'($urandom_range(1)),
            $urandom_range(15) == 0);
    end

    // Full adder from two instances plus OR.
    for (int i = 0; i < 8; i++) begin
      fa_a = i[2]; fa_b = i[1]; fa_c = i[0];
      fa_exp = int'(fa_a) + int'(fa_b) + int'(fa_c);
      #(3 * GD + 1);
      check("full_adder", int'({fa_co, fa_s}), fa_exp);
      #GD;
    end
    repeat (2) @(posedge clk);
    #1;
    check("fa_h1_err", int'(h1_err), 0);
    check("fa_h2_err", int'(h2_err), 0);
    check("sat_err", int'(s_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/half_adder2.md
Name: half_adder2

Overview:
- Single-bit half adder: sum = a XOR b, carry = a AND b.
- Combinational outputs are built from gate primitives with modelled gate delay, so the full-adder layer (two half adders plus an OR gate) keeps its zero-cycle path.
- Adds a registered copy of the result with a valid flag, plus saturating activity counters, for pipelined users and bring-up visibility.

Parameters:
- GATE_DELAY, 50: simulation delay, in time units, per gate primitive on the combinational path. Synthesis ignores it.
- CNT_W, 16: width of op_count and carry_count.

Ports:
- clk  in  1  single clock; all registers update on rising edge.
- rst  in  1  synchronous reset, active-high.
- a  in  1  addend bit.
- b  in  1  addend bit.
- sum  out  1  combinational a XOR b, through one gate of GATE_DELAY.
- carry  out  1  combinational a AND b, through one gate of GATE_DELAY.
- in_valid  in  1  qualifies a/b for the registered stage and counters.
- cnt_clr  in  1  synchronous clear of both counters.
- sum_q  out  1  registered sum.
- carry_q  out  1  registered carry.
- out_valid  out  1  registered in_valid.
- op_count  out  CNT_W  count of accepted operations (in_valid=1 cycles).
- carry_count  out  CNT_W  count of accepted operations with carry=1.
- err  out  1  sticky self-check error (see Optional Feature).

Behaviour:
- Combinational path:
  - sum = xor primitive(a,b); carry = and primitive(a,b); each with #GATE_DELAY.
  - No clock dependence. Outputs settle GATE_DELAY after the last input change.
  - Truth table: 00->s0 c0; 01->s1 c0; 10->s1 c0; 11->s0 c1.
- Registered stage:
  - Uses an internal zero-delay copy (a^b, a&b), so captured values never depend on GATE_DELAY versus clock timing.
- Reset, rising clk with rst=1:
  - sum_q=0, carry_q=0, out_valid=0, op_count=0, carry_count=0, err=0.
  - Reset overrides all other inputs, including cnt_clr and in_valid.
- Normal cycle, rst=0:
  - out_valid <= in_valid.
  - If in_valid=1: sum_q <= a^b, carry_q <= a&b.
  - If in_valid=0: sum_q/carry_q hold their values.
  - Latency is exactly 1 cycle from in_valid to out_valid.
- Counters:
  - If cnt_clr=1: both counters <= 0. The current cycle's operation is not counted; clear wins over increment.
  - Else, if in_valid=1: op_count += 1; and if a&b=1, carry_count += 1.
  - Both counters saturate at 2^CNT_W-1 (no wrap). Invariant: carry_count <= op_count.
- There is no handshake back-pressure; every in_valid=1 cycle is accepted.
- Mid-operation reset discards the pending captured result: out_valid reads 0 on the following cycle.

Optional Feature:
- Macro HALFADDER2_CHECK_EN.
- Defined: on each accepted cycle, compare {carry,sum} sampled at the clock edge against the 2-bit arithmetic a+b.
  - The check is skipped unless the inputs have been stable at least GATE_DELAY before the edge; the sim-only stability tracker is tracked per input change.
  - On mismatch, err <= 1 and stays 1 until rst. In simulation, a $display error message is also issued.
- Not defined: err is tied to 0 and no checker logic or stability tracking is built.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=b=1 -> sum_q=0, carry_q=0, out_valid=0, counters 0, err=0.
- Exhaustive combinational check: apply a,b = 00,01,10,11, waiting >GATE_DELAY each -> sum/carry = 0/0, 1/0, 1/0, 0/1; outputs unchanged at GATE_DELAY-1 after the input change.
- Registered path: in_valid=1 with a=1,b=1, then in_valid=0 with a=1,b=0 -> next cycle sum_q=0, carry_q=1, out_valid=1; following cycle out_valid=0 and sum_q/carry_q hold 0/1.
- Counting: 4 valid ops with ab = 11,01,11,00 -> op_count=4, carry_count=2.
- Clear priority: cnt_clr=1 together with in_valid=1, a=b=1 -> both counters 0 next cycle. With CNT_W=2, 5 valid 11 ops -> op_count=3 and carry_count=3 (saturated).
- Full-adder integration: two half_adder2 instances plus OR, all 8 combinations of a,b,c -> sum/carry match a+b+c after 3*GATE_DELAY. With HALFADDER2_CHECK_EN defined, err stays 0.
